// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns the PC and the handshake with a variable-latency instruction memory.
// It also handles stalls, branch/jump redirects and redirects that arrive while a fetch is outstanding.
// Optional: define FETCH_PERF_CNT_EN to add a saturating fetchCountOut counter.
module if_fetch_stage #(
   parameter int unsigned PC_WIDTH   = 12,
   parameter int unsigned INST_WIDTH = 19,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stallIF,
   input  logic                  branchTaken,
   input  logic [PC_WIDTH-1:0]   branchTarget,
   input  logic                  jumpTaken,
   input  logic [PC_WIDTH-1:0]   jumpTarget,
   output logic                  imemReq,
   output logic [PC_WIDTH-1:0]   imemAddr,
   input  logic                  imemReady,
   input  logic [INST_WIDTH-1:0] imemData,
   output logic [PC_WIDTH-1:0]   pcPlusOneIF,
   output logic [INST_WIDTH-1:0] instIF,
   output logic                  instValidIF,
   output logic                  fetchBubbleIF
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]           fetchCountOut
`endif
);

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] HOLD  = 2'd1;
   localparam logic [1:0] DROP  = 2'd2;

   logic [1:0]            state, state_nxt;
   logic [PC_WIDTH-1:0]   pc, pc_nxt;
   logic [PC_WIDTH-1:0]   saved_target, saved_target_nxt;
   logic [INST_WIDTH-1:0] hold_reg, hold_reg_nxt;
   logic                  redirect;
   logic [PC_WIDTH-1:0]   target;
   logic [PC_WIDTH-1:0]   pc_inc;

   assign redirect = branchTaken | jumpTaken;
   assign target   = branchTaken ? branchTarget : jumpTarget;
   assign pc_inc   = pc + PC_WIDTH'(1);

   // State, PC, hold buffer and pending redirect target registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= FETCH;
         pc           <= RESET_PC;
         hold_reg     <= '0;
         saved_target <= '0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         hold_reg     <= hold_reg_nxt;
         saved_target <= saved_target_nxt;
      end
   end

   // Next-state and PC update
   always_comb begin
      state_nxt        = state;
      pc_nxt           = pc;
      hold_reg_nxt     = hold_reg;
      saved_target_nxt = saved_target;
      case (state)
         FETCH: begin
            if (imemReady) begin
               if (redirect) begin
                  pc_nxt = target;
               end else if (stallIF) begin
                  hold_reg_nxt = imemData;
                  state_nxt    = HOLD;
               end else begin
                  pc_nxt = pc_inc;
               end
            end else if (redirect) begin
               // Address must stay stable until the memory answers
               saved_target_nxt = target;
               state_nxt        = DROP;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_nxt    = target;
               state_nxt = FETCH;
            end else if (!stallIF) begin
               pc_nxt    = pc_inc;
               state_nxt = FETCH;
            end
         end
         DROP: begin
            if (redirect) begin
               saved_target_nxt = target;
            end
            if (imemReady) begin
               pc_nxt    = redirect ? target : saved_target;
               state_nxt = FETCH;
            end
         end
         default: begin
            state_nxt = FETCH;
         end
      endcase
   end

   // Memory request and IF/ID-facing outputs
   always_comb begin
      imemReq       = ~rst & (state != HOLD);
      imemAddr      = pc;
      pcPlusOneIF   = pc_inc;
      instValidIF   = ((state == FETCH) & imemReady & ~redirect) |
                      ((state == HOLD) & ~redirect);
      instIF        = '0;
      if (instValidIF) begin
         instIF = (state == HOLD) ? hold_reg : imemData;
      end
      fetchBubbleIF = ~instValidIF & ~stallIF;
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_count;

   // Saturating count of instructions handed to IF/ID
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= '0;
      end else if (instValidIF && !stallIF && (fetch_count != 16'hFFFF)) begin
         fetch_count <= fetch_count + 16'd1;
      end
   end

   assign fetchCountOut = fetch_count;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage with hand-computed expectations.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallIF;
   logic        branchTaken;
   logic [11:0] branchTarget;
   logic        jumpTaken;
   logic [11:0] jumpTarget;
   logic        imemReq;
   logic [11:0] imemAddr;
   logic        imemReady;
   logic [18:0] imemData;
   logic [11:0] pcPlusOneIF;
   logic [18:0] instIF;
   logic        instValidIF;
   logic        fetchBubbleIF;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetchCountOut;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   if_fetch_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stallIF       (stallIF),
      .branchTaken   (branchTaken),
      .branchTarget  (branchTarget),
      .jumpTaken     (jumpTaken),
      .jumpTarget    (jumpTarget),
      .imemReq       (imemReq),
      .imemAddr      (imemAddr),
      .imemReady     (imemReady),
      .imemData      (imemData),
      .pcPlusOneIF   (pcPlusOneIF),
      .instIF        (instIF),
      .instValidIF   (instValidIF),
      .fetchBubbleIF (fetchBubbleIF)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetchCountOut (fetchCountOut)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply inputs and let combinational outputs settle
   task automatic drive(input logic s, input logic r, input logic [18:0] d,
                        input logic b, input logic [11:0] bt,
                        input logic j, input logic [11:0] jt);
      stallIF      = s;
      imemReady    = r;
      imemData     = d;
      branchTaken  = b;
      branchTarget = bt;
      jumpTaken    = j;
      jumpTarget   = jt;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 19'h0, 0, 12'h0, 0, 12'h0);
      check("rst_req", 32'(imemReq), 32'd0);
      check("rst_addr", 32'(imemAddr), 32'd0);
      check("rst_inst", 32'(instIF), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Zero-wait streaming from reset: pc 0..4
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 19'(100 + i), 0, 12'h0, 0, 12'h0);
         check("zw_addr", 32'(imemAddr), 32'(i));
         check("zw_pc1", 32'(pcPlusOneIF), 32'(i + 1));
         check("zw_valid", 32'(instValidIF), 32'd1);
         check("zw_bubble", 32'(fetchBubbleIF), 32'd0);
         check("zw_inst", 32'(instIF), 32'(100 + i));
         check("zw_req", 32'(imemReq), 32'd1);
         tick();
      end

      // Two wait states at pc=5
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 19'h7FFFF, 0, 12'h0, 0, 12'h0);
         check("wait_addr", 32'(imemAddr), 32'd5);
         check("wait_bubble", 32'(fetchBubbleIF), 32'd1);
         check("wait_inst", 32'(instIF), 32'd0);
         check("wait_req", 32'(imemReq), 32'd1);
         tick();
      end
      drive(0, 1, 19'h12345, 0, 12'h0, 0, 12'h0);
      check("wait_rdy_inst", 32'(instIF), 32'h12345);
      check("wait_rdy_valid", 32'(instValidIF), 32'd1);
      tick();
      drive(0, 1, 19'h00006, 0, 12'h0, 0, 12'h0);
      check("after_wait_addr", 32'(imemAddr), 32'd6);
      tick();
      drive(0, 1, 19'h00007, 0, 12'h0, 0, 12'h0);
      tick();

      // Stall for three cycles while fetching pc=8
      drive(1, 1, 19'h1ABCD, 0, 12'h0, 0, 12'h0);
      check("stall_addr", 32'(imemAddr), 32'd8);
      check("stall_inst0", 32'(instIF), 32'h1ABCD);
      check("stall_bub0", 32'(fetchBubbleIF), 32'd0);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 19'h7FFFF, 0, 12'h0, 0, 12'h0);
         check("hold_req", 32'(imemReq), 32'd0);
         check("hold_inst", 32'(instIF), 32'h1ABCD);
         check("hold_valid", 32'(instValidIF), 32'd1);
         check("hold_bubble", 32'(fetchBubbleIF), 32'd0);
         check("hold_addr", 32'(imemAddr), 32'd8);
         tick();
      end
      drive(0, 0, 19'h7FFFF, 0, 12'h0, 0, 12'h0);
      check("rel_inst", 32'(instIF), 32'h1ABCD);
      check("rel_valid", 32'(instValidIF), 32'd1);
      tick();
      drive(0, 1, 19'h00009, 0, 12'h0, 0, 12'h0);
      check("rel_next_addr", 32'(imemAddr), 32'd9);
      tick();

      // Jump to 20 from pc=10 with ready data: data is dropped
      drive(0, 1, 19'h0000A, 0, 12'h0, 1, 12'd20);
      check("jmp_valid", 32'(instValidIF), 32'd0);
      check("jmp_bubble", 32'(fetchBubbleIF), 32'd1);
      check("jmp_inst", 32'(instIF), 32'd0);
      tick();

      // Redirects arriving during a 3-cycle wait at pc=20
      drive(0, 0, 19'h7FFFF, 0, 12'h0, 1, 12'h100);
      check("drop_addr0", 32'(imemAddr), 32'd20);
      check("drop_bub0", 32'(fetchBubbleIF), 32'd1);
      tick();
      drive(0, 0, 19'h7FFFF, 1, 12'h200, 0, 12'h0);
      check("drop_addr1", 32'(imemAddr), 32'd20);
      check("drop_req1", 32'(imemReq), 32'd1);
      check("drop_valid1", 32'(instValidIF), 32'd0);
      tick();
      drive(0, 1, 19'h55555, 0, 12'h0, 0, 12'h0);
      check("drop_addr2", 32'(imemAddr), 32'd20);
      check("drop_valid2", 32'(instValidIF), 32'd0);
      check("drop_inst2", 32'(instIF), 32'd0);
      check("drop_bub2", 32'(fetchBubbleIF), 32'd1);
      tick();

      // Branch and stall in the same cycle: branch wins, no bubble while stalled
      drive(1, 1, 19'h00200, 1, 12'd4095, 0, 12'h0);
      check("tgt_addr", 32'(imemAddr), 32'h200);
      check("bs_valid", 32'(instValidIF), 32'd0);
      check("bs_bubble", 32'(fetchBubbleIF), 32'd0);
      tick();

      // PC wrap at 4095
      drive(0, 1, 19'h00FFF, 0, 12'h0, 0, 12'h0);
      check("wrap_addr", 32'(imemAddr), 32'd4095);
      check("wrap_req", 32'(imemReq), 32'd1);
      check("wrap_pc1", 32'(pcPlusOneIF), 32'd0);
      check("wrap_valid", 32'(instValidIF), 32'd1);
      tick();
      drive(0, 1, 19'h00000, 0, 12'h0, 0, 12'h0);
      check("wrap_next", 32'(imemAddr), 32'd0);
      tick();

      // Enter HOLD at pc=1, then reset mid-hold
      drive(1, 1, 19'h02468, 0, 12'h0, 0, 12'h0);
      tick();
      drive(1, 0, 19'h7FFFF, 0, 12'h0, 0, 12'h0);
      check("prerst_req", 32'(imemReq), 32'd0);
      check("prerst_inst", 32'(instIF), 32'h02468);
      check("prerst_addr", 32'(imemAddr), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_req", 32'(imemReq), 32'd0);
      check("midrst_addr", 32'(imemAddr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 0, 19'h7FFFF, 0, 12'h0, 0, 12'h0);
      check("postrst_req", 32'(imemReq), 32'd1);
      check("postrst_addr", 32'(imemAddr), 32'd0);
      check("postrst_inst", 32'(instIF), 32'd0);
      check("postrst_bub", 32'(fetchBubbleIF), 32'd0);
      tick();
      drive(0, 1, 19'h00042, 0, 12'h0, 0, 12'h0);
      check("postrst_run", 32'(instIF), 32'h42);
      tick();
      drive(0, 1, 19'h00043, 0, 12'h0, 0, 12'h0);
      check("postrst_next", 32'(imemAddr), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the IF/ID pipeline register. It holds the PC, issues requests to a variable-latency instruction memory, and presents pcPlusOneIF/instIF to IF/ID. It absorbs stalls, branch/jump redirects and memory wait states. It raises a bubble request, which the hazard unit ORs into flushIFID, whenever no valid instruction is available.

Parameters:
PC_WIDTH, 12, PC/address width
INST_WIDTH, 19, instruction width
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
stallIF  input  1  hold current instruction (same signal as stallIFID)
branchTaken  input  1  branch redirect request
branchTarget  input  PC_WIDTH  branch target
jumpTaken  input  1  jump redirect request
jumpTarget  input  PC_WIDTH  jump target
imemReq  output  1  memory request
imemAddr  output  PC_WIDTH  request address (equals pc)
imemReady  input  1  data valid this cycle; may be combinational same-cycle
imemData  input  INST_WIDTH  instruction data
pcPlusOneIF  output  PC_WIDTH  pc+1, to IF/ID
instIF  output  INST_WIDTH  instruction, to IF/ID
instValidIF  output  1  instIF is valid this cycle
fetchBubbleIF  output  1  request IF/ID flush

Behaviour:
- Reset (async): pc=RESET_PC, state=FETCH, holdReg=0, savedTarget=0. imemReq=0 while rst is high.
- redirect = branchTaken|jumpTaken. target = branchTaken ? branchTarget : jumpTarget (branch has priority).
- Memory rule: imemReq stays high and imemAddr stays stable until imemReady=1 is sampled. Data is valid only in the imemReady cycle. Zero-wait memory gives 1 instruction/cycle.
- imemReq=1 in FETCH and DROP, 0 in HOLD. imemAddr=pc at all times.
- pcPlusOneIF = pc+1 modulo 2^PC_WIDTH (4095 wraps to 0). This is combinational from pc.
- instValidIF = (FETCH & imemReady & ~redirect) | (HOLD & ~redirect).
- instIF = imemData in FETCH, holdReg in HOLD, all-zero (NOP) when instValidIF=0.
- fetchBubbleIF = ~instValidIF & ~stallIF. It is never asserted while stalled, so the instruction held in IF/ID is not destroyed.
- State FETCH:
  - imemReady & redirect: pc<=target, stay FETCH; returned data is discarded.
  - imemReady & stallIF: holdReg<=imemData, go HOLD; pc unchanged.
  - imemReady & neither: pc<=pc+1, stay FETCH.
  - ~imemReady & redirect: savedTarget<=target, go DROP; address is kept stable.
  - ~imemReady & no redirect: stay.
- State HOLD:
  - redirect: pc<=target, go FETCH.
  - ~stallIF: pc<=pc+1, go FETCH.
  - else stay; instIF=holdReg stable.
- State DROP: instValidIF=0.
  - Redirect while in DROP: savedTarget<=target (newest wins).
  - imemReady: data discarded, pc<=savedTarget (or the same-cycle redirect target), go FETCH.
- Redirect with stall in the same cycle: redirect wins.
- stallIF with no valid instruction: no bubble, state proceeds as above.
- Reset mid-request abandons the transaction. The memory must tolerate imemReq dropping.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds output port fetchCountOut[15:0]. It increments on every cycle with instValidIF & ~stallIF, saturates at 65535, and resets to 0. When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Zero-wait memory (imemReady=1), no stall, after reset -> imemAddr 0,1,2,3 on consecutive cycles; pcPlusOneIF 1,2,3,4; instValidIF=1 every cycle; fetchBubbleIF=0.
- imemReady low 2 cycles at pc=5 -> imemAddr held at 5; fetchBubbleIF=1 for 2 cycles; instIF=0. On the ready cycle instIF=imemData, then pc=6.
- stallIF=1 for 3 cycles while fetching pc=8 (data 0x1ABCD) -> HOLD; instIF=0x1ABCD stable; imemReq=0; fetchBubbleIF=0. Stall release -> next imemAddr=9.
- jumpTaken (target 0x100) during a 3-cycle wait at pc=20, branchTaken (target 0x200) one cycle later -> address 20 held until ready, data discarded, next imemAddr=0x200.
- pc=4095 with zero-wait memory -> pcPlusOneIF=0; next imemAddr=0.
- rst asserted while in HOLD -> imemReq=0 immediately; after release imemAddr=RESET_PC; holdReg cleared.
